// File: rtl/dog_sprite_render_if.sv
// Pixel-stream bundle between VGA timing/ROM side and the dog sprite renderer.
// The slave modport is the renderer's view; master is the driving environment.
interface dog_sprite_render_if;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        de;
    logic [11:0] bg_rgb;
    logic        ActionS;
    logic [9:0]  DogPos_x1;
    logic [9:0]  DogPos_x2;
    logic [8:0]  DogPos_y;
    logic [12:0] rom_addr;
    logic [11:0] rom_data;
    logic [11:0] rgb;
    logic        rgb_de;

    modport master (
        output h_cnt, v_cnt, de, bg_rgb, ActionS,
        output DogPos_x1, DogPos_x2, DogPos_y, rom_data,
        input  rom_addr, rgb, rgb_de
    );

    modport slave (
        input  h_cnt, v_cnt, de, bg_rgb, ActionS,
        input  DogPos_x1, DogPos_x2, DogPos_y, rom_data,
        output rom_addr, rgb, rgb_de
    );
endinterface

// File: rtl/dog_sprite_render.sv
// Two-stage sprite compositor: stage 1 issues the sprite ROM address, stage 2
// keys the ROM pixel over the background. Position/frame are latched once per frame.
module dog_sprite_render #(
    parameter int          SPR_W = 64,
    parameter int          SPR_H = 64,
    parameter logic [11:0] KEY   = 12'hF0F
) (
    input  logic               pixel_clk,
    input  logic               reset,
    dog_sprite_render_if.slave bus
);

    localparam logic [9:0] SPR_W_L = 10'(SPR_W);
    localparam logic [9:0] SPR_H_L = 10'(SPR_H);
    localparam logic [9:0] LOAD_V  = 10'd480;

    logic [9:0]  sx1_r;
    logic [9:0]  sx2_r;
    logic [8:0]  sy_r;
    logic        sact_r;

    logic        load_s;
    logic [9:0]  sy_ext_s;
    logic [9:0]  col_s;
    logic [9:0]  row_s;
    logic        hit_s;
    logic [12:0] addr_s;

    logic [12:0] rom_addr_r;
    logic        hit_d1_r;
    logic        de_d1_r;
    logic [11:0] bg_d1_r;

    logic [11:0] pix_s;
    logic [11:0] rgb_r;
    logic        rgb_de_r;

    // Stage 1 geometry: sx2<=sx1 can never satisfy h>=sx1 && h<sx2, so it disables the sprite
    always_comb begin
        load_s   = (bus.h_cnt == 10'd0) && (bus.v_cnt == LOAD_V);
        sy_ext_s = {1'b0, sy_r};
        col_s    = bus.h_cnt - sx1_r;
        row_s    = bus.v_cnt - sy_ext_s;
        hit_s    = bus.de
                && (bus.h_cnt >= sx1_r) && (bus.h_cnt < sx2_r) && (col_s < SPR_W_L)
                && (bus.v_cnt >= sy_ext_s) && (row_s < SPR_H_L);
        if (hit_s) begin
            addr_s = {sact_r, row_s[5:0], col_s[5:0]};
        end else begin
            addr_s = 13'd0;
        end
    end

    // Shadow position/frame, refreshed only at the start of vertical blanking
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            sx1_r  <= 10'd256;
            sx2_r  <= 10'd320;
            sy_r   <= 9'd300;
            sact_r <= 1'b0;
        end else if (load_s) begin
            sx1_r  <= bus.DogPos_x1;
            sx2_r  <= bus.DogPos_x2;
            sy_r   <= bus.DogPos_y;
            sact_r <= bus.ActionS;
        end
    end

    // Stage 1 registers: ROM address plus the pixel attributes travelling with it
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            rom_addr_r <= 13'd0;
            hit_d1_r   <= 1'b0;
            de_d1_r    <= 1'b0;
            bg_d1_r    <= 12'd0;
        end else begin
            rom_addr_r <= addr_s;
            hit_d1_r   <= hit_s;
            de_d1_r    <= bus.de;
            bg_d1_r    <= bus.bg_rgb;
        end
    end

    // Stage 2 colour select: KEY-coloured sprite texels fall through to background
    always_comb begin
        if (!de_d1_r) begin
            pix_s = 12'd0;
        end else if (hit_d1_r && (bus.rom_data != KEY)) begin
            pix_s = bus.rom_data;
        end else begin
            pix_s = bg_d1_r;
        end
    end

    // Stage 2 registers driving the video output
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            rgb_r    <= 12'd0;
            rgb_de_r <= 1'b0;
        end else begin
            rgb_r    <= pix_s;
            rgb_de_r <= de_d1_r;
        end
    end

    assign bus.rom_addr = rom_addr_r;
    assign bus.rgb      = rgb_r;
    assign bus.rgb_de   = rgb_de_r;

endmodule
